// File: rtl/pin_keypad_entry_if.sv
// Keypad-side bundle for pin_keypad_entry: raw key inputs and the assembled
// PIN outputs. The slave modport is the entry block; master is its driver.
// Key_locked exists only when PIN_ENTRY_LOCKOUT_EN is defined.
interface pin_keypad_entry_if;
  logic       Key_valid;
  logic [3:0] Key_code;
  logic [7:0] Pin;
  logic       enterPin;
  logic [1:0] Digit_count;
  logic       Entry_error;
`ifdef PIN_ENTRY_LOCKOUT_EN
  logic       Key_locked;

  modport master (
    output Key_valid, Key_code,
    input  Pin, enterPin, Digit_count, Entry_error, Key_locked
  );

  modport slave (
    input  Key_valid, Key_code,
    output Pin, enterPin, Digit_count, Entry_error, Key_locked
  );
`else
  modport master (
    output Key_valid, Key_code,
    input  Pin, enterPin, Digit_count, Entry_error
  );

  modport slave (
    input  Key_valid, Key_code,
    output Pin, enterPin, Digit_count, Entry_error
  );
`endif
endinterface

// File: rtl/pin_keypad_entry.sv
// pin_keypad_entry: synchronizes and debounces the keypad "key held" line,
// assembles two BCD digits into Pin and strobes enterPin on a valid enter.
// Handles clear, enter-too-early / third-digit errors and inactivity timeout.
// Optional macro PIN_ENTRY_LOCKOUT_EN adds a three-strikes lockout and the
// Key_locked output.
module pin_keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input logic               Clk,
  input logic               Reset,
  pin_keypad_entry_if.slave kp
);

  localparam int unsigned     DB_W     = 16;
  localparam int unsigned     TO_W     = 20;
  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ONE,
    TWO,
    SEND
  } state_t;

  state_t          state, state_n;
  logic            sync1, sync2, deb_level;
  logic [DB_W-1:0] deb_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      hi_q, lo_q, hi_n, lo_n;
  logic [7:0]      pin_q;
  logic            err_q, err_n;
  logic            load_pin;
  logic            press, key_live;
  logic            ev_digit, ev_clear, ev_enter, ev_any;
  logic            expire;
  logic [1:0]      digit_count;

`ifdef PIN_ENTRY_LOCKOUT_EN
  localparam int unsigned       LOCK_W   = TO_W + 3;
  localparam logic [LOCK_W-1:0] LOCK_LEN = LOCK_W'(8 * TIMEOUT_CYCLES);

  logic [1:0]        err_run;
  logic [LOCK_W-1:0] lock_cnt;
  logic              locked, lock_start;

  assign locked     = (lock_cnt != '0);
  assign lock_start = err_n && (err_run == 2'd2);
  assign key_live   = !locked;
`else
  assign key_live   = 1'b1;
`endif

  // Two-flop synchronizer followed by a saturating-match debounce counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1 <= kp.Key_valid;
      sync2 <= sync1;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_LIMIT) begin
        deb_level <= ~deb_level;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // The press event is the cycle in which the debounced level is about to
  // rise, so the FSM acts on the same edge that flips deb_level.
  assign press    = sync2 && !deb_level && (deb_cnt == DB_LIMIT) && key_live;
  assign ev_digit = press && (kp.Key_code <= 4'd9);
  assign ev_clear = press && (kp.Key_code == 4'hC);
  assign ev_enter = press && (kp.Key_code == 4'hE);
  assign ev_any   = ev_digit || ev_clear || ev_enter;
  assign expire   = ((state == ONE) || (state == TWO)) && (to_cnt == TO_LAST);

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, buffer and error decisions; a press event takes priority
  // over a simultaneous timeout expiry.
  always_comb begin
    state_n  = state;
    hi_n     = hi_q;
    lo_n     = lo_q;
    err_n    = 1'b0;
    load_pin = 1'b0;
    unique case (state)
      IDLE: begin
        if (ev_digit) begin
          hi_n    = kp.Key_code;
          lo_n    = '0;
          state_n = ONE;
        end else if (ev_enter) begin
          err_n = 1'b1;
        end
      end
      ONE: begin
        if (ev_digit) begin
          lo_n    = kp.Key_code;
          state_n = TWO;
        end else if (ev_enter) begin
          err_n   = 1'b1;
          hi_n    = '0;
          state_n = IDLE;
        end else if (ev_clear || expire) begin
          hi_n    = '0;
          state_n = IDLE;
        end
      end
      TWO: begin
        if (ev_digit) begin
          err_n = 1'b1;
        end else if (ev_enter) begin
          load_pin = 1'b1;
          state_n  = SEND;
        end else if (ev_clear || expire) begin
          hi_n    = '0;
          lo_n    = '0;
          state_n = IDLE;
        end
      end
      SEND: begin
        hi_n    = '0;
        lo_n    = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef PIN_ENTRY_LOCKOUT_EN
    if (lock_start) begin
      hi_n    = '0;
      lo_n    = '0;
      state_n = IDLE;
    end
`endif
  end

  // Digit buffer, output PIN register and registered error pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      pin_q <= '0;
      err_q <= 1'b0;
    end else begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      err_q <= err_n;
      if (load_pin) begin
        pin_q <= {hi_q, lo_q};
      end
    end
  end

  // Inactivity timer: counts only while digits are buffered and the state
  // is steady; any accepted key restarts it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      to_cnt <= '0;
    end else if (ev_any || (state_n != state) ||
                 !((state == ONE) || (state == TWO))) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef PIN_ENTRY_LOCKOUT_EN
  // Consecutive-error tracking and lockout timer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_run  <= '0;
      lock_cnt <= '0;
    end else begin
      if (lock_start) begin
        err_run  <= '0;
        lock_cnt <= LOCK_LEN;
      end else begin
        if (load_pin) begin
          err_run <= '0;
        end else if (err_n) begin
          err_run <= err_run + 1'b1;
        end
        if (locked) begin
          lock_cnt <= lock_cnt - 1'b1;
        end
      end
    end
  end

  assign kp.Key_locked = locked;
`endif

  // Digit count follows the FSM state; forced to zero while locked out.
  always_comb begin
    digit_count = 2'd0;
    unique case (state)
      ONE:     digit_count = 2'd1;
      TWO:     digit_count = 2'd2;
      default: digit_count = 2'd0;
    endcase
`ifdef PIN_ENTRY_LOCKOUT_EN
    if (locked) begin
      digit_count = 2'd0;
    end
`endif
  end

  assign kp.Pin         = pin_q;
  assign kp.enterPin    = (state == SEND);
  assign kp.Digit_count = digit_count;
  assign kp.Entry_error = err_q;

endmodule

// File: tb/tb_pin_keypad_entry.sv
// Testbench for pin_keypad_entry: directed scenarios plus randomized key
// sequences, with expected strobes/errors queued by a digit-count model and
// checked by an independent monitor.
module tb_pin_keypad_entry;
  localparam int unsigned DB = 4;
  localparam int unsigned TO = 50;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  pin_keypad_entry_if bus();

  pin_keypad_entry #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .kp   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: digits held, pending strobes/errors, error streak.
  logic [7:0] exp_pin_q[$];
  int         exp_err = 0;
  int         m_cnt = 0;
  logic [3:0] m_hi = '0;
  logic [3:0] m_lo = '0;
  int         err_run = 0;
  bit         lock_pending = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
               name, act, act, req, req, $time);
    end
  endtask

  task automatic model_err();
    exp_err++;
    err_run++;
`ifdef PIN_ENTRY_LOCKOUT_EN
    if (err_run == 3) begin
      m_cnt = 0;
      err_run = 0;
      lock_pending = 1'b1;
    end
`endif
  endtask

  task automatic model_key(input logic [3:0] c);
    if (c <= 4'd9) begin
      if (m_cnt == 0) begin
        m_hi = c;
        m_cnt = 1;
      end else if (m_cnt == 1) begin
        m_lo = c;
        m_cnt = 2;
      end else begin
        model_err();
      end
    end else if (c == 4'hC) begin
      m_cnt = 0;
    end else if (c == 4'hE) begin
      if (m_cnt == 2) begin
        exp_pin_q.push_back({m_hi, m_lo});
        m_cnt = 0;
        err_run = 0;
      end else begin
        m_cnt = 0;
        model_err();
      end
    end
  endtask

  // Clean key press: hold, release, then confirm all expected responses
  // arrived and the digit count agrees with the model.
  task automatic press(input logic [3:0] c, input int hold, input int gap,
                       input bit modelled);
    if (modelled) model_key(c);
    bus.Key_code = c;
    bus.Key_valid = 1'b1;
    repeat (hold) @(posedge Clk);
    #1;
    bus.Key_valid = 1'b0;
    repeat (gap) @(posedge Clk);
    #1;
    check("Digit_count", int'(bus.Digit_count), m_cnt);
    check("strobe_outstanding", exp_pin_q.size(), 0);
    check("error_outstanding", exp_err, 0);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_Pin", int'(bus.Pin), 0);
    check("rst_Digit_count", int'(bus.Digit_count), 0);
    check("rst_enterPin", int'(bus.enterPin), 0);
`ifdef PIN_ENTRY_LOCKOUT_EN
    check("rst_Key_locked", int'(bus.Key_locked), 0);
`endif
    m_cnt = 0;
    err_run = 0;
    lock_pending = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

`ifdef PIN_ENTRY_LOCKOUT_EN
  // Bounded wait for the lockout to end; returns cycles spent locked.
  task automatic wait_unlock(output int n);
    n = 0;
    check("Key_locked_on", int'(bus.Key_locked), 1);
    while (bus.Key_locked && n < 8 * TO + 50) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("Key_locked_released", int'(bus.Key_locked), 0);
    lock_pending = 1'b0;
  endtask
`endif

  // Monitor: consume expected strobes/errors as the DUT presents them.
  initial begin : monitor
    logic [7:0] prev_pin;
    logic       prev_err;
    logic       prev_ent;
    prev_pin = '0;
    prev_err = 1'b0;
    prev_ent = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_pin = bus.Pin;
        prev_err = 1'b0;
        prev_ent = 1'b0;
        continue;
      end
      if (bus.enterPin) begin
        check("enterPin_width", int'(prev_ent), 0);
        check("Digit_count_in_send", int'(bus.Digit_count), 0);
        if (exp_pin_q.size() == 0) check("enterPin_unexpected", int'(bus.enterPin), 0);
        else check("Pin_on_strobe", int'(bus.Pin), int'(exp_pin_q.pop_front()));
      end else if (bus.Pin !== prev_pin) begin
        check("Pin_hold", int'(bus.Pin), int'(prev_pin));
      end
      if (bus.Entry_error) begin
        check("Entry_error_width", int'(prev_err), 0);
        if (exp_err == 0) check("Entry_error_unexpected", int'(bus.Entry_error), 0);
        else exp_err--;
      end
      prev_pin = bus.Pin;
      prev_err = bus.Entry_error;
      prev_ent = bus.enterPin;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit prev_ign;
    int n;
    bus.Key_valid = 1'b0;
    bus.Key_code = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_Pin", int'(bus.Pin), 0);
    check("reset_Digit_count", int'(bus.Digit_count), 0);
    check("reset_enterPin", int'(bus.enterPin), 0);
    check("reset_Entry_error", int'(bus.Entry_error), 0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // 4, 2, enter with first-press latency measured edge by edge.
    model_key(4'h4);
    bus.Key_code = 4'h4;
    bus.Key_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge Clk);
      #1;
      if (k == 6) check("latency_before", int'(bus.Digit_count), 0);
      if (k == 7) check("latency_at", int'(bus.Digit_count), 1);
    end
    repeat (3) @(posedge Clk);
    #1;
    bus.Key_valid = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    press(4'h2, 10, 10, 1'b1);
    press(4'hE, 10, 10, 1'b1);
    check("Pin_after_42", int'(bus.Pin), 8'h42);

    // Reset in the middle of an entry discards the digit and clears Pin.
    press(4'h7, 10, 10, 1'b1);
    do_reset();
    repeat (20) @(posedge Clk);
    #1;
    check("post_reset_Digit_count", int'(bus.Digit_count), 0);

    // Bouncing line produces no event; then a clean 5.
    bus.Key_code = 4'h5;
    for (int i = 0; i < 10; i++) begin
      bus.Key_valid = ~bus.Key_valid;
      repeat (2) @(posedge Clk);
      #1;
    end
    check("bounce_no_event", int'(bus.Digit_count), 0);
    press(4'h5, 10, 10, 1'b1);
    press(4'hC, 10, 10, 1'b1);

    // Enter after one digit, third digit rejected, then a good 12.
    press(4'h3, 10, 10, 1'b1);
    press(4'hE, 10, 10, 1'b1);
    press(4'h1, 10, 10, 1'b1);
    press(4'h2, 10, 10, 1'b1);
    press(4'h9, 10, 10, 1'b1);
    press(4'hE, 10, 10, 1'b1);
    check("Pin_after_12", int'(bus.Pin), 8'h12);

    // Inactivity timeout, then clear after two digits.
    press(4'h8, 10, 10, 1'b1);
    repeat (20) @(posedge Clk);
    #1;
    check("timeout_not_yet", int'(bus.Digit_count), 1);
    repeat (30) @(posedge Clk);
    #1;
    m_cnt = 0;
    check("timeout_expired", int'(bus.Digit_count), 0);
    press(4'h6, 10, 10, 1'b1);
    press(4'h6, 10, 10, 1'b1);
    press(4'hC, 10, 10, 1'b1);

    // Randomized key sequences with occasional long idles.
    prev_ign = 1'b0;
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [3:0] c;
      r = int'($urandom_range(0, 21));
      if (r == 21) begin
        repeat (70) @(posedge Clk);
        #1;
        m_cnt = 0;
        check("rand_idle_count", int'(bus.Digit_count), 0);
        prev_ign = 1'b0;
        continue;
      end
      if (r <= 9) c = 4'(r);
      else if (r <= 14) c = 4'hE;
      else if (r <= 16) c = 4'hC;
      else if (prev_ign) c = 4'($urandom_range(0, 9));
      else begin
        logic [3:0] ign [4];
        ign[0] = 4'hA; ign[1] = 4'hB; ign[2] = 4'hD; ign[3] = 4'hF;
        c = ign[$urandom_range(0, 3)];
      end
      prev_ign = (c == 4'hA) || (c == 4'hB) || (c == 4'hD) || (c == 4'hF);
      press(c, int'($urandom_range(8, 10)), int'($urandom_range(8, 10)), 1'b1);
`ifdef PIN_ENTRY_LOCKOUT_EN
      if (lock_pending) wait_unlock(n);
`endif
    end

`ifdef PIN_ENTRY_LOCKOUT_EN
    // Three bare enters lock the keypad; digits are ignored while locked.
    do_reset();
    press(4'hE, 10, 10, 1'b1);
    press(4'hE, 10, 10, 1'b1);
    press(4'hE, 10, 10, 1'b1);
    check("lock_Key_locked", int'(bus.Key_locked), 1);
    press(4'h3, 10, 10, 1'b0);
    check("lock_digit_ignored", int'(bus.Digit_count), 0);
    wait_unlock(n);
    check("lock_length_ok", int'(n >= 360 && n <= 372), 1);
    press(4'h1, 10, 10, 1'b1);
    press(4'h1, 10, 10, 1'b1);
    press(4'hE, 10, 10, 1'b1);
    check("Pin_after_11", int'(bus.Pin), 8'h11);
`endif

    repeat (10) @(posedge Clk);
    #1;
    check("final_strobes_pending", exp_pin_q.size(), 0);
    check("final_errors_pending", exp_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pin_keypad_entry.md
Name: pin_keypad_entry

Overview:
- Upstream stage of the parking-gate controller. Turns raw keypad presses into the 8-bit `Pin` word and the one-cycle `enterPin` strobe the controller consumes.
- Synchronizes and debounces the key-valid line, then assembles two BCD digits.
- Supports clear, enter and inactivity-timeout handling. Flags malformed entries to the rest of the system.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronized cycles a key level must hold before it is accepted (range 1..65535).
- TIMEOUT_CYCLES, 1000: idle cycles after a first digit before the partial entry is discarded (range 1..2^20-1).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Key_valid  input  1  raw asynchronous keypad "key held" level.
- Key_code  input  4  keypad code; stable while Key_valid is high. 0x0-0x9 = digit, 0xC = clear, 0xE = enter, others = no-op.
- Pin  output  8  assembled PIN, {first digit, second digit} in BCD; registered.
- enterPin  output  1  one-cycle strobe; Pin is valid in the same cycle.
- Digit_count  output  2  digits currently buffered (0..2).
- Entry_error  output  1  one-cycle pulse on a rejected key.

Behaviour:
- Clock and reset:
  - Single clock Clk. Reset is asynchronous and active-high.
  - Reset clears all state: Pin=8'h00, enterPin=0, Digit_count=0, Entry_error=0, FSM=IDLE, debounced level=0, counters=0.
  - Reset mid-entry discards buffered digits. No strobe is emitted.
- Input conditioning:
  - Key_valid passes through a 2-flop synchronizer.
  - Debounce counter increments while the synchronized value differs from the debounced level. It clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Key acceptance:
  - A press event is a debounced 0->1 transition. Key_code is captured that cycle.
  - Releases generate no event. Holding a key never repeats.
  - Latency: a clean high on Key_valid produces the press event 2+DEBOUNCE_CYCLES cycles after the first Clk edge sampling it high.
- FSM states: IDLE (0 digits), ONE (1 digit), TWO (2 digits), SEND.
  - IDLE: digit -> store as high nibble, go ONE. Enter -> Entry_error. Clear/no-op -> stay.
  - ONE: digit -> store as low nibble, go TWO. Enter -> Entry_error, go IDLE, buffer cleared. Clear -> IDLE.
  - TWO: digit -> Entry_error, buffer unchanged (third digit rejected). Enter -> go SEND. Clear -> IDLE.
  - SEND: lasts exactly one cycle, then IDLE with the internal buffer cleared. Key events cannot occur here: a press event is at least DEBOUNCE_CYCLES apart from the preceding one.
- Pin and enterPin:
  - Pin loads the buffer on entry to SEND. enterPin=1 during the SEND cycle only.
  - Pin holds its value until the next SEND. Pin never changes outside a strobe.
  - Strobe occurs the cycle after the enter press event.
- Outputs:
  - Entry_error is registered and asserts for exactly one cycle, the cycle after the offending press event.
  - Digit_count reflects the FSM: IDLE=0, ONE=1, TWO=2, SEND=0.
- Inactivity timeout:
  - The timeout counter runs in ONE and TWO. It clears on any press event and on state change.
  - When it reaches TIMEOUT_CYCLES, FSM goes to IDLE and the buffer clears. No error pulse.
  - A press event in the same cycle as expiry wins: it is processed and the counter clears.
- Digit-only codes (0x0-0x9) are stored. Codes 0xA, 0xB, 0xD, 0xF are ignored in every state and do not reset the timeout.

Optional Feature:
- Macro: PIN_ENTRY_LOCKOUT_EN.
- When defined:
  - A 2-bit counter tracks consecutive Entry_error pulses. Any successful SEND clears it.
  - The third consecutive error forces a lockout of 8*TIMEOUT_CYCLES cycles.
  - During lockout all press events are discarded, Digit_count=0, and an extra output `Key_locked` (1 bit) is high.
  - Reset clears the lockout.
- When undefined: no counter, no `Key_locked` port. Errors have no cumulative effect.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50):
1. Reset asserted mid-cycle with buffered digit 7 -> Pin=00, Digit_count=0, enterPin=0 immediately (asynchronous), no strobe after release.
2. Keys 4, 2, enter, each held 10 cycles with 10-cycle gaps -> exactly one enterPin pulse, Pin=8'h42 that cycle and afterwards, Digit_count 1, 2, 0.
3. Key_valid bouncing 1/0 every 2 cycles for 20 cycles, then stable high with code 5 -> single press event, Digit_count=1; no events during bounce.
4. Digit 3, then enter -> Entry_error one-cycle pulse, Digit_count=0, no enterPin. Digits 1, 2, 9 -> Entry_error on 9, then enter -> Pin=8'h12.
5. Digit 8, then idle 50 cycles -> Digit_count returns to 0, no error, no strobe. Clear after digits 6, 6 -> Digit_count=0.
6. With PIN_ENTRY_LOCKOUT_EN: three bare enters -> Key_locked=1 for 400 cycles, digits ignored. Afterwards 1, 1, enter -> Pin=8'h11.
